or_gate_lab1a: RTL and testbench

Parameterised bitwise two-input OR block with a combinational result, a registered copy and a saturating activity counter. Used as the basic logic primitive in the lab datapath, where the combinational output feeds local logic and the registered outputs feed clocked consumers and debug monitoring.

---
 rtl/or_gate_lab1a.sv | 82 ++++++++
 tb/tb_or_gate_lab1a.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/or_gate_lab1a.sv
// or_gate_lab1a: bitwise two-input OR with a combinational result,
// a registered copy, a registered reduction-OR and an optional
// saturating count of cycles whose OR result was non-zero.
//
// Build option: define OR_GATE_LAB1A_HIT_CNT_EN to build the hit counter.
// When the macro is undefined, hit_cnt is tied to zero and clr is ignored.
module or_gate_lab1a #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_q,
    output logic             any_q,
    output logic [CNT_W-1:0] hit_cnt
);

    logic [WIDTH-1:0] or_d;
    logic             any_d;

    // Combinational OR result, valid regardless of clock or reset.
    always_comb begin
        or_d  = a | b;
        any_d = |or_d;
        c     = or_d;
    end

    // Registered copy of the OR result and its reduction; cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q   <= '0;
            any_q <= 1'b0;
        end else begin
            c_q   <= or_d;
            any_q <= any_d;
        end
    end

`ifdef OR_GATE_LAB1A_HIT_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] hit_cnt_d;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    // Next count: clear beats a simultaneous hit, otherwise count hits.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (clr) begin
            hit_cnt_d = '0;
        end else if (any_d) begin
            hit_cnt_d = sat_inc(hit_cnt_q);
        end
    end

    // Counter register; reset overrides clear and any hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
`else
    // Counter not built: clear has no effect and the count reads zero.
    logic unused_clr;
    assign unused_clr = clr;
    assign hit_cnt    = '0;
`endif

endmodule

// File: tb/tb_or_gate_lab1a.sv
module tb_or_gate_lab1a;

`ifdef OR_GATE_LAB1A_HIT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        a1, b1;
    logic        c1, c_q1, any_q1;
    logic [15:0] hit1;
    logic [3:0]  a4, b4;
    logic [3:0]  c4, c_q4;
    logic        any_q4;
    logic [3:0]  hit4;

    int checks = 0;
    int failures = 0;

    // Reference model state (plain integers, counted from the rules).
    int m_cq1, m_any1, m_cnt1;
    int m_cq4, m_any4, m_cnt4;

    always #5 clk = ~clk;

    or_gate_lab1a #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .clr(clr),
        .c(c1), .c_q(c_q1), .any_q(any_q1), .hit_cnt(hit1)
    );

    or_gate_lab1a #(.WIDTH(4), .CNT_W(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .clr(clr),
        .c(c4), .c_q(c_q4), .any_q(any_q4), .hit_cnt(hit4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, update the model from the sampled inputs, check outputs.
    task automatic tick();
        int cmax1, cmax4, or1, or4;
        @(posedge clk);
        cmax1 = 65535;
        cmax4 = 15;
        or1 = int'(a1) | int'(b1);
        or4 = int'(a4) | int'(b4);
        if (rst_n !== 1'b1) begin
            m_cq1 = 0; m_any1 = 0; m_cnt1 = 0;
            m_cq4 = 0; m_any4 = 0; m_cnt4 = 0;
        end else begin
            m_cq1 = or1; m_any1 = (or1 != 0) ? 1 : 0;
            m_cq4 = or4; m_any4 = (or4 != 0) ? 1 : 0;
            if (!CNT_EN) begin
                m_cnt1 = 0; m_cnt4 = 0;
            end else if (clr) begin
                m_cnt1 = 0; m_cnt4 = 0;
            end else begin
                if (or1 != 0 && m_cnt1 < cmax1) m_cnt1 = m_cnt1 + 1;
                if (or4 != 0 && m_cnt4 < cmax4) m_cnt4 = m_cnt4 + 1;
            end
        end
        #1;
        chk("c_q_w1", 32'(c_q1), 32'(m_cq1));
        chk("any_q_w1", 32'(any_q1), 32'(m_any1));
        chk("hit_w1", 32'(hit1), 32'(m_cnt1));
        chk("c_q_w4", 32'(c_q4), 32'(m_cq4));
        chk("any_q_w4", 32'(any_q4), 32'(m_any4));
        chk("hit_w4", 32'(hit4), 32'(m_cnt4));
    endtask

    initial begin
        logic [1:0] tt;
        rst_n = 1'b0; clr = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a4 = '0; b4 = '0;
        m_cq1 = 0; m_any1 = 0; m_cnt1 = 0;
        m_cq4 = 0; m_any4 = 0; m_cnt4 = 0;

        // Combinational truth table, held in reset.
        for (int i = 0; i < 4; i++) begin
            tt = 2'(i);
            a1 = tt[1]; b1 = tt[0];
            #10;
            chk("truth_c", 32'(c1), (i == 0) ? 32'd0 : 32'd1);
        end

        // Reset with a=b=1: c valid, registers zero.
        a1 = 1'b1; b1 = 1'b1; a4 = 4'b0001; b4 = 4'b0000;
        tick(); tick();
        chk("rst_c", 32'(c1), 32'd1);
        chk("rst_cq", 32'(c_q1), 32'd0);
        chk("rst_any", 32'(any_q1), 32'd0);
        chk("rst_hit", 32'(hit1), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_cq", 32'(c_q1), 32'd1);
        chk("rel_any", 32'(any_q1), 32'd1);
        chk("rel_hit", 32'(hit1), CNT_EN ? 32'd1 : 32'd0);

        // Latency and counting on the 4-bit instance.
        clr = 1'b1; a4 = '0; b4 = '0; a1 = 1'b0; b1 = 1'b0;
        tick();
        clr = 1'b0; a4 = 4'b0101; b4 = 4'b1000;
        #1 chk("w4_c", 32'(c4), 32'hD);
        tick();
        chk("w4_cq_lat", 32'(c_q4), 32'hD);
        tick(); tick();
        chk("w4_hit3", 32'(hit4), CNT_EN ? 32'd3 : 32'd0);
        a4 = '0; b4 = '0;
        tick(); tick();
        chk("w4_hold", 32'(hit4), CNT_EN ? 32'd3 : 32'd0);
        chk("w4_any0", 32'(any_q4), 32'd0);

        // Saturation at 15 with CNT_W=4.
        a4 = 4'b0001;
        for (int i = 0; i < 20; i++) tick();
        chk("w4_sat", 32'(hit4), CNT_EN ? 32'd15 : 32'd0);

        // Clear wins over a simultaneous hit.
        clr = 1'b1; tick();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("clr_pre5", 32'(hit4), CNT_EN ? 32'd5 : 32'd0);
        clr = 1'b1; tick();
        chk("clr_win", 32'(hit4), 32'd0);
        clr = 1'b0; tick();
        chk("clr_after", 32'(hit4), CNT_EN ? 32'd1 : 32'd0);

        // Reset mid-count discards the count.
        tick(); tick();
        rst_n = 1'b0; tick();
        chk("mid_rst", 32'(hit4), 32'd0);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom);
            if ($urandom_range(3) == 0) begin
                a4 = '0; b4 = '0;
            end
            clr = ($urandom_range(7) == 0);
            rst_n = ($urandom_range(31) != 0);
            #1;
            chk("rnd_c_w1", 32'(c1), 32'(a1 | b1));
            chk("rnd_c_w4", 32'(c4), 32'(a4 | b4));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
